// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: fetch FSM states and the
// queue entry layout.
package fetch_queue_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int FQ_WORD     = 32;

   typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} fq_state_e;

   typedef struct packed {
      logic [FQ_WORD-1:0] instr;
      logic [FQ_WORD-1:0] ofs;
      logic               err;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head entry is read straight from
// registered storage at the read pointer.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             do_push, do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);

   // Pointers are AW bits wide, so increments wrap modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= din;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop) rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   assign dout = mem[rptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch FSM on the I-memory req/ack
// port feeding a DEPTH-entry FIFO drained by decode via valid/ready.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int                     WORD_LENGTH = 32,
   parameter int                     DEPTH       = 4,
   parameter logic [WORD_LENGTH-1:0] RESET_OFS   = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirValid,
   input  logic [WORD_LENGTH-1:0]   redirOfs,
   output logic                     imemReq,
   output logic [WORD_LENGTH-1:0]   imemOfs,
   input  logic                     imemAck,
   input  logic [WORD_LENGTH-1:0]   imemData,
   input  logic                     imemErr,
   output logic                     outValid,
   input  logic                     outReady,
   output logic [WORD_LENGTH-1:0]   outInstr,
   output logic [WORD_LENGTH-1:0]   outOfs,
   output logic                     outErr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = 2*WORD_LENGTH + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fq_state_e              state, state_n;
   logic [WORD_LENGTH-1:0] pc, pc_n, redir_pc;
   logic                   push, pop, flush;
   logic [CW-1:0]          count_next;
   logic [EW-1:0]          head;

   assign redir_pc = redirOfs & ~WORD_LENGTH'(INSTR_BYTES-1);

   // imemReq/imemOfs are registered from the next state; in DISCARD the
   // offset of the abandoned request is held until its ack arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= RESET_OFS;
         imemReq <= 1'b0;
         imemOfs <= RESET_OFS;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         imemReq <= (state_n == REQ) || (state_n == DISCARD);
         if (state_n != DISCARD) imemOfs <= pc_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      if (redirValid) begin
         pc_n = redir_pc;
         if (((state == REQ) || (state == DISCARD)) && !imemAck) state_n = DISCARD;
         else                                                    state_n = REQ;
      end else begin
         case (state)
            IDLE:    if (count < FULL) state_n = REQ;
            REQ:     if (imemAck) begin
                        pc_n = pc + WORD_LENGTH'(INSTR_BYTES);
                        if (imemErr)                 state_n = HALT;
                        else if (count_next < FULL)  state_n = REQ;
                        else                         state_n = IDLE;
                     end
            DISCARD: if (imemAck) state_n = REQ;
            HALT:    state_n = HALT;
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      flush      = redirValid;
      push       = (state == REQ) && imemAck && !redirValid;
      pop        = outValid && outReady && !redirValid;
      count_next = count + CW'(push) - CW'(pop);
   end

   sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   ({imemData, pc, imemErr}),
      .dout  (head),
      .count (count)
   );

   assign outValid = (count != '0);
   assign {outInstr, outOfs, outErr} = head;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run against a
// queue-level reference model of the fetch stream.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int          D    = 4;
   localparam logic [31:0] ROFS = 32'h100;

   logic        clk = 1'b0, rst = 1'b1;
   logic        redirValid = 1'b0, imemAck = 1'b0, imemErr = 1'b0, outReady = 1'b0;
   logic [31:0] redirOfs = '0, imemData = '0;
   logic        imemReq, outValid, outErr;
   logic [31:0] imemOfs, outInstr, outOfs;
   logic [2:0]  count;

   int n_checks = 0, n_pass = 0;

   fetch_queue #(.WORD_LENGTH(32), .DEPTH(D), .RESET_OFS(ROFS)) dut (
      .clk(clk), .rst(rst), .redirValid(redirValid), .redirOfs(redirOfs),
      .imemReq(imemReq), .imemOfs(imemOfs), .imemAck(imemAck), .imemData(imemData),
      .imemErr(imemErr), .outValid(outValid), .outReady(outReady), .outInstr(outInstr),
      .outOfs(outOfs), .outErr(outErr), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      rst = 1; redirValid = 0; imemAck = 0; imemErr = 0; outReady = 0;
      tick; tick;
      rst = 0;
      tick;
   endtask

   task automatic test_reset;
      rst = 1;
      tick; tick;
      n_checks++; if (imemReq !== 1'b0) $display("FAIL reset_req got %b exp 0", imemReq); else n_pass++;
      n_checks++; if (imemOfs !== ROFS) $display("FAIL reset_ofs got %h exp %h", imemOfs, ROFS); else n_pass++;
      n_checks++; if (outValid !== 1'b0) $display("FAIL reset_valid got %b exp 0", outValid); else n_pass++;
      n_checks++; if (outInstr !== 32'h0) $display("FAIL reset_instr got %h exp 0", outInstr); else n_pass++;
      n_checks++; if (outOfs !== 32'h0) $display("FAIL reset_outofs got %h exp 0", outOfs); else n_pass++;
      n_checks++; if (outErr !== 1'b0) $display("FAIL reset_err got %b exp 0", outErr); else n_pass++;
      n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
      rst = 0;
      tick;
      n_checks++; if (imemReq !== 1'b1) $display("FAIL first_req got %b exp 1", imemReq); else n_pass++;
      n_checks++; if (imemOfs !== ROFS) $display("FAIL first_ofs got %h exp %h", imemOfs, ROFS); else n_pass++;
   endtask

   task automatic test_stream;
      logic [31:0] a;
      do_reset;
      outReady = 1;
      for (int k = 0; k < 5; k++) begin
         a = ROFS + 32'(4*k);
         n_checks++; if (imemOfs !== a || imemReq !== 1'b1) $display("FAIL stream_ofs%0d got %b/%h exp 1/%h", k, imemReq, imemOfs, a); else n_pass++;
         if (k > 0) begin
            n_checks++; if (outValid !== 1'b1 || outOfs !== a - 32'd4 || outInstr !== memword(a - 32'd4))
               $display("FAIL stream_out%0d got %b/%h/%h exp 1/%h/%h", k, outValid, outOfs, outInstr, a - 32'd4, memword(a - 32'd4));
            else n_pass++;
         end
         imemAck = 1; imemData = memword(imemOfs);
         tick;
      end
      imemAck = 0;
   endtask

   task automatic test_backpressure;
      int acks = 0;
      do_reset;
      outReady = 0;
      for (int i = 0; i < 8; i++) begin
         if (imemReq) begin imemAck = 1; imemData = memword(imemOfs); acks++; end
         else imemAck = 0;
         tick;
      end
      imemAck = 0;
      n_checks++; if (acks !== 4) $display("FAIL bp_acks got %0d exp 4", acks); else n_pass++;
      n_checks++; if (imemReq !== 1'b0) $display("FAIL bp_req got %b exp 0", imemReq); else n_pass++;
      n_checks++; if (count !== 3'd4) $display("FAIL bp_count got %0d exp 4", count); else n_pass++;
      n_checks++; if (outOfs !== ROFS) $display("FAIL bp_head got %h exp %h", outOfs, ROFS); else n_pass++;
      outReady = 1;
      tick;
      outReady = 0;
      for (int i = 0; i < 6 && !imemReq; i++) tick;
      n_checks++; if (imemReq !== 1'b1 || imemOfs !== 32'h110) $display("FAIL bp_reissue got %b/%h exp 1/00000110", imemReq, imemOfs); else n_pass++;
      n_checks++; if (count !== 3'd3) $display("FAIL bp_count3 got %0d exp 3", count); else n_pass++;
   endtask

   task automatic test_redirect_discard;
      do_reset;
      outReady = 1;
      redirValid = 1; redirOfs = 32'h2003;
      tick;
      redirValid = 0;
      n_checks++; if (count !== 3'd0) $display("FAIL disc_count got %0d exp 0", count); else n_pass++;
      n_checks++; if (imemReq !== 1'b1 || imemOfs !== ROFS) $display("FAIL disc_hold got %b/%h exp 1/%h", imemReq, imemOfs, ROFS); else n_pass++;
      tick; tick;
      imemAck = 1; imemData = 32'hDEAD_BEEF;
      tick;
      imemAck = 0;
      n_checks++; if (outValid !== 1'b0) $display("FAIL disc_dropped got %b exp 0", outValid); else n_pass++;
      n_checks++; if (imemReq !== 1'b1 || imemOfs !== 32'h2000) $display("FAIL disc_newofs got %b/%h exp 1/00002000", imemReq, imemOfs); else n_pass++;
      imemAck = 1; imemData = memword(imemOfs);
      tick;
      imemAck = 0;
      n_checks++; if (outValid !== 1'b1 || outOfs !== 32'h2000 || outInstr !== memword(32'h2000))
         $display("FAIL disc_first got %b/%h/%h exp 1/00002000/%h", outValid, outOfs, outInstr, memword(32'h2000));
      else n_pass++;
   endtask

   task automatic test_redirect_same_cycle;
      do_reset;
      outReady = 1;
      redirValid = 1; redirOfs = 32'h40; imemAck = 1; imemData = memword(imemOfs);
      tick;
      redirValid = 0; imemAck = 0;
      n_checks++; if (imemReq !== 1'b1 || imemOfs !== 32'h40 || outValid !== 1'b0)
         $display("FAIL same_first got %b/%h/%b exp 1/00000040/0", imemReq, imemOfs, outValid);
      else n_pass++;
      imemAck = 1; imemData = memword(32'h40); redirValid = 1; redirOfs = 32'h300;
      tick;
      imemAck = 0; redirValid = 0;
      n_checks++; if (imemReq !== 1'b1 || imemOfs !== 32'h300) $display("FAIL same_redir got %b/%h exp 1/00000300", imemReq, imemOfs); else n_pass++;
      n_checks++; if (count !== 3'd0) $display("FAIL same_count got %0d exp 0", count); else n_pass++;
      tick;
      n_checks++; if (outValid !== 1'b0) $display("FAIL same_dropped got %b exp 0", outValid); else n_pass++;
   endtask

   task automatic test_fault;
      do_reset;
      outReady = 0;
      redirValid = 1; redirOfs = 32'h80; imemAck = 1;
      tick;
      redirValid = 0;
      imemAck = 1; imemErr = 1; imemData = memword(imemOfs);
      tick;
      imemAck = 0; imemErr = 0;
      n_checks++; if (outValid !== 1'b1 || outErr !== 1'b1 || outOfs !== 32'h80)
         $display("FAIL fault_entry got %b/%b/%h exp 1/1/00000080", outValid, outErr, outOfs);
      else n_pass++;
      n_checks++; if (imemReq !== 1'b0) $display("FAIL fault_halt got %b exp 0", imemReq); else n_pass++;
      repeat (4) tick;
      n_checks++; if (imemReq !== 1'b0 || outErr !== 1'b1) $display("FAIL fault_hold got %b/%b exp 0/1", imemReq, outErr); else n_pass++;
      redirValid = 1; redirOfs = 32'h500;
      tick;
      redirValid = 0;
      n_checks++; if (imemReq !== 1'b1 || imemOfs !== 32'h500 || outValid !== 1'b0)
         $display("FAIL fault_resume got %b/%h/%b exp 1/00000500/0", imemReq, imemOfs, outValid);
      else n_pass++;
   endtask

   task automatic test_wrap_and_reset;
      do_reset;
      outReady = 0;
      redirValid = 1; redirOfs = 32'hFFFF_FFFC; imemAck = 1;
      tick;
      redirValid = 0;
      n_checks++; if (imemOfs !== 32'hFFFF_FFFC) $display("FAIL wrap_pre got %h exp fffffffc", imemOfs); else n_pass++;
      imemAck = 1; imemData = memword(imemOfs);
      tick;
      imemAck = 0;
      n_checks++; if (imemReq !== 1'b1 || imemOfs !== 32'h0) $display("FAIL wrap_ofs got %b/%h exp 1/00000000", imemReq, imemOfs); else n_pass++;
      n_checks++; if (outValid !== 1'b1 || outOfs !== 32'hFFFF_FFFC) $display("FAIL wrap_out got %b/%h exp 1/fffffffc", outValid, outOfs); else n_pass++;
      rst = 1; imemAck = 1; imemData = 32'h1234_5678;
      tick;
      n_checks++; if (imemReq !== 1'b0 || imemOfs !== ROFS || outValid !== 1'b0 || count !== 3'd0 ||
                      outInstr !== 32'h0 || outOfs !== 32'h0 || outErr !== 1'b0)
         $display("FAIL midrst got req=%b ofs=%h v=%b cnt=%0d i=%h o=%h e=%b", imemReq, imemOfs, outValid, count, outInstr, outOfs, outErr);
      else n_pass++;
      rst = 0;
      tick;
      imemAck = 0;
      n_checks++; if (count !== 3'd0 || outValid !== 1'b0) $display("FAIL midrst_ack got %0d/%b exp 0/0", count, outValid); else n_pass++;
      n_checks++; if (imemReq !== 1'b1 || imemOfs !== ROFS) $display("FAIL midrst_req got %b/%h exp 1/%h", imemReq, imemOfs, ROFS); else n_pass++;
   endtask

   // Model: the decode-visible stream is the sequence of acked words not
   // killed by a redirect, at consecutive offsets from the last redirect.
   task automatic test_random;
      fq_entry_t   q[$];
      logic [31:0] exp_pc, old_ofs;
      bit          disc, halted, req_s;
      int          pushes = 0, errs = 0;
      do_reset;
      exp_pc = ROFS; old_ofs = '0; disc = 0; halted = 0;
      for (int c = 0; c < 3000; c++) begin
         n_checks++; if (int'(count) !== q.size()) begin errs++; if (errs < 10) $display("FAIL rnd_count c=%0d got %0d exp %0d", c, count, q.size()); end else n_pass++;
         n_checks++; if (outValid !== (q.size() != 0)) begin errs++; if (errs < 10) $display("FAIL rnd_valid c=%0d got %b", c, outValid); end else n_pass++;
         if (q.size() != 0) begin
            n_checks++; if ({outInstr, outOfs, outErr} !== q[0]) begin errs++; if (errs < 10) $display("FAIL rnd_head c=%0d got %h/%h/%b exp %h/%h/%b", c, outInstr, outOfs, outErr, q[0].instr, q[0].ofs, q[0].err); end else n_pass++;
         end
         if (imemReq) begin
            n_checks++; if (imemOfs !== (disc ? old_ofs : exp_pc)) begin errs++; if (errs < 10) $display("FAIL rnd_ofs c=%0d got %h exp %h", c, imemOfs, disc ? old_ofs : exp_pc); end else n_pass++;
         end
         if (halted || (q.size() == D && !disc)) begin
            n_checks++; if (imemReq !== 1'b0) begin errs++; if (errs < 10) $display("FAIL rnd_noreq c=%0d got %b exp 0", c, imemReq); end else n_pass++;
         end
         req_s      = imemReq;
         redirValid = ($urandom_range(0, 19) == 0);
         redirOfs   = $urandom;
         imemAck    = req_s && ($urandom_range(0, 1) == 1);
         imemData   = $urandom;
         imemErr    = ($urandom_range(0, 31) == 0);
         outReady   = ($urandom_range(0, 1) == 1);
         if (redirValid) begin
            q.delete();
            if (req_s && !imemAck) begin
               if (!disc) old_ofs = exp_pc;
               disc = 1;
            end else disc = 0;
            exp_pc = redirOfs & ~32'd3;
            halted = 0;
         end else begin
            if (outReady && q.size() != 0) void'(q.pop_front());
            if (req_s && imemAck) begin
               if (disc) disc = 0;
               else begin
                  q.push_back('{instr: imemData, ofs: exp_pc, err: imemErr});
                  exp_pc = exp_pc + 32'd4;
                  pushes++;
                  if (imemErr) halted = 1;
               end
            end
         end
         tick;
      end
      redirValid = 0; imemAck = 0; outReady = 0;
      n_checks++; if (pushes < 200) $display("FAIL rnd_progress got %0d exp >=200", pushes); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_stream;
      test_backpressure;
      test_redirect_discard;
      test_redirect_same_cycle;
      test_fault;
      test_wrap_and_reset;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
